// File: rtl/pad_addr_pkg.sv
// Shared widths, sequencer state encoding and command payload for the padded address generator.
package pad_addr_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned CNT_W  = 13;
    localparam int unsigned REP_W  = 8;
    localparam int unsigned N_LOOP = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } seq_state_e;

    // Loop index 3 is the innermost sweep, index 0 the outermost.
    typedef struct packed {
        logic [ADDR_W-1:0]             base;
        logic [N_LOOP-1:0][ADDR_W-1:0] gap;
        logic [N_LOOP-1:0][CNT_W-1:0]  lenth;
        logic [REP_W-1:0]              repeat_num;
    } pad_addr_cfg_t;

endpackage

// File: rtl/pad_addr_outer_cnt.sv
// Three-level odometer mirroring loops 2/1/0 (loop2 fastest); flags the final outer position.
module pad_addr_outer_cnt
    import pad_addr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  logic [CNT_W-1:0] len2,
    input  logic [CNT_W-1:0] len1,
    input  logic [CNT_W-1:0] len0,
    output logic             last_c
);

    logic [CNT_W-1:0] o2_q;
    logic [CNT_W-1:0] o1_q;
    logic [CNT_W-1:0] o0_q;
    logic             end2;
    logic             end1;
    logic             end0;

    assign end2   = (o2_q == len2);
    assign end1   = (o1_q == len1);
    assign end0   = (o0_q == len0);
    assign last_c = end2 & end1 & end0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o2_q <= '0;
            o1_q <= '0;
            o0_q <= '0;
        end else if (clr) begin
            o2_q <= '0;
            o1_q <= '0;
            o0_q <= '0;
        end else if (adv) begin
            if (!end2) begin
                o2_q <= o2_q + CNT_W'(1);
            end else begin
                o2_q <= '0;
                if (!end1) begin
                    o1_q <= o1_q + CNT_W'(1);
                end else begin
                    o1_q <= '0;
                    o0_q <= end0 ? '0 : o0_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pad_addr_seq.sv
// Sequencer for the 4-level padded address generator: latches a command, steps the
// generator, replays each loop3 sweep and streams addresses on valid/ready.
module pad_addr_seq
    import pad_addr_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_start,
    input  logic                     cmd_abort,
    input  logic [ADDR_W-1:0]        cmd_base_addr,
    input  logic [N_LOOP*ADDR_W-1:0] cmd_gap,
    input  logic [N_LOOP*CNT_W-1:0]  cmd_lenth,
    input  logic [REP_W-1:0]         cmd_repeat_num,
    output logic [ADDR_W-1:0]        mu_base_addr,
    output logic [N_LOOP*ADDR_W-1:0] mu_gap,
    output logic [N_LOOP*CNT_W-1:0]  mu_lenth,
    output logic                     mu_init,
    output logic                     mu_step,
    output logic                     mu_record,
    output logic                     mu_repeat,
    input  logic [ADDR_W-1:0]        mu_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    seq_state_e       state_q;
    seq_state_e       state_d;
    pad_addr_cfg_t    cfg_q;
    pad_addr_cfg_t    cmd_cfg;
    logic [CNT_W-1:0] beat_q;
    logic [CNT_W-1:0] beat_d;
    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] rep_d;
    logic             outer_adv;
    logic             outer_clr;
    logic             outer_last_c;
    logic             start_ok;
    logic             beat_end;
    logic             rep_end;

    assign cmd_cfg  = {cmd_base_addr, cmd_gap, cmd_lenth, cmd_repeat_num};
    assign start_ok = (state_q == S_IDLE) && cmd_start && !cmd_abort;
    assign beat_end = (beat_q == cfg_q.lenth[3]);
    assign rep_end  = (rep_q == cfg_q.repeat_num);

    assign mu_base_addr = cfg_q.base;
    assign mu_gap       = cfg_q.gap;
    assign mu_lenth     = cfg_q.lenth;
    assign out_addr     = mu_addr;
    assign busy         = (state_q != S_IDLE);

    pad_addr_outer_cnt u_outer (
        .clk    (clk),
        .rst    (rst),
        .clr    (outer_clr),
        .adv    (outer_adv),
        .len2   (cfg_q.lenth[2]),
        .len1   (cfg_q.lenth[1]),
        .len0   (cfg_q.lenth[0]),
        .last_c (outer_last_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rep_q   <= rep_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q <= '0;
        end else if (start_ok) begin
            cfg_q <= cmd_cfg;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rep_d     = rep_q;
        outer_adv = 1'b0;
        outer_clr = 1'b0;
        mu_init   = 1'b0;
        mu_step   = 1'b0;
        mu_record = 1'b0;
        mu_repeat = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_INIT;
            end
            S_INIT: begin
                mu_init = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                out_valid = 1'b1;
                mu_record = (beat_q == '0) && (rep_q == '0);
                out_last  = beat_end && rep_end && outer_last_c;
                if (out_ready) begin
                    if (!beat_end) begin
                        mu_step = 1'b1;
                        beat_d  = beat_q + CNT_W'(1);
                    end else if (!rep_end) begin
                        // Replay: generator reloads the recorded sweep-start address.
                        mu_step   = 1'b1;
                        mu_repeat = 1'b1;
                        beat_d    = '0;
                        rep_d     = rep_q + REP_W'(1);
                    end else if (!outer_last_c) begin
                        mu_step   = 1'b1;
                        beat_d    = '0;
                        rep_d     = '0;
                        outer_adv = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                beat_d    = '0;
                rep_d     = '0;
                outer_clr = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a same-cycle accept.
        if (cmd_abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            beat_d    = '0;
            rep_d     = '0;
            outer_adv = 1'b0;
            outer_clr = 1'b1;
            mu_init   = 1'b0;
            mu_step   = 1'b0;
            mu_record = 1'b0;
            mu_repeat = 1'b0;
            out_valid = 1'b0;
            out_last  = 1'b0;
            done      = 1'b0;
        end
    end

endmodule

// File: tb/tb_pad_addr_seq.sv
// Scoreboard bench for pad_addr_seq with a behavioural 4-level address generator.
module tb_pad_addr_seq;
    import pad_addr_pkg::*;

    logic                     clk;
    logic                     rst;
    logic                     cmd_start;
    logic                     cmd_abort;
    logic [ADDR_W-1:0]        cmd_base_addr;
    logic [N_LOOP*ADDR_W-1:0] cmd_gap;
    logic [N_LOOP*CNT_W-1:0]  cmd_lenth;
    logic [REP_W-1:0]         cmd_repeat_num;
    logic [ADDR_W-1:0]        mu_base_addr;
    logic [N_LOOP*ADDR_W-1:0] mu_gap;
    logic [N_LOOP*CNT_W-1:0]  mu_lenth;
    logic                     mu_init;
    logic                     mu_step;
    logic                     mu_record;
    logic                     mu_repeat;
    logic [ADDR_W-1:0]        mu_addr;
    logic                     out_valid;
    logic                     out_ready;
    logic [ADDR_W-1:0]        out_addr;
    logic                     out_last;
    logic                     busy;
    logic                     done;

    pad_addr_seq dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_start      (cmd_start),
        .cmd_abort      (cmd_abort),
        .cmd_base_addr  (cmd_base_addr),
        .cmd_gap        (cmd_gap),
        .cmd_lenth      (cmd_lenth),
        .cmd_repeat_num (cmd_repeat_num),
        .mu_base_addr   (mu_base_addr),
        .mu_gap         (mu_gap),
        .mu_lenth       (mu_lenth),
        .mu_init        (mu_init),
        .mu_step        (mu_step),
        .mu_record      (mu_record),
        .mu_repeat      (mu_repeat),
        .mu_addr        (mu_addr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_addr       (out_addr),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              last;
        logic              rep;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    logic rdy_toggle = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural generator: loop3 innermost, record/repeat restore the sweep-start indices.
    logic [N_LOOP-1:0][CNT_W-1:0] gidx;
    logic [N_LOOP-1:0][CNT_W-1:0] ridx;

    function automatic logic [N_LOOP-1:0][CNT_W-1:0] odo_next(
        input logic [N_LOOP-1:0][CNT_W-1:0] idx,
        input logic [N_LOOP*CNT_W-1:0]      len
    );
        logic [N_LOOP-1:0][CNT_W-1:0] n;
        n = idx;
        for (int i = N_LOOP - 1; i >= 0; i--) begin
            if (n[i] < len[i*CNT_W +: CNT_W]) begin
                n[i] = n[i] + CNT_W'(1);
                return n;
            end
            n[i] = '0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gidx <= '0;
            ridx <= '0;
        end else begin
            if (mu_record) ridx <= gidx;
            if (mu_init)        gidx <= '0;
            else if (mu_repeat) gidx <= ridx;
            else if (mu_step)   gidx <= odo_next(gidx, mu_lenth);
        end
    end

    always_comb begin
        logic [31:0] s;
        s = 32'(mu_base_addr);
        for (int i = 0; i < N_LOOP; i++)
            s = s + 32'(gidx[i]) * 32'(mu_gap[i*ADDR_W +: ADDR_W]);
        mu_addr = ADDR_W'(s);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Consumer ready: held high, or toggled every cycle when rdy_toggle is set.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_toggle ? ~out_ready : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted beat and checks stall behaviour.
    initial begin
        exp_t              e;
        logic              stall_prev;
        logic              last_prev;
        logic [ADDR_W-1:0] addr_prev;
        stall_prev = 1'b0;
        last_prev  = 1'b0;
        addr_prev  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                last_prev  = 1'b0;
            end else begin
                if (last_prev) chk("done_after_last", 32'(done), 32'd1);
                if (stall_prev && out_valid) chk("stall_addr_stable", 32'(out_addr), 32'(addr_prev));
                if (out_valid && !out_ready) chk("stall_no_step", 32'({mu_step, mu_repeat}), 32'd0);
                last_prev = 1'b0;
                if (out_valid && out_ready) begin
                    n_acc++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got addr 0x%0h expected no beat at %0t", out_addr, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_addr", 32'(out_addr), 32'(e.addr));
                        chk("beat_last", 32'(out_last), 32'(e.last));
                        chk("beat_repeat", 32'(mu_repeat), 32'(e.rep));
                        last_prev = out_last;
                    end
                end
                stall_prev = out_valid && !out_ready;
                addr_prev  = out_addr;
            end
        end
    end

    task automatic push(input logic [ADDR_W-1:0] a, input logic l, input logic r);
        exp_t e;
        e.addr = a;
        e.last = l;
        e.rep  = r;
        exp_q.push_back(e);
    endtask

    task automatic push_t2();
        push(13'h100, 1'b0, 1'b0);
        push(13'h104, 1'b0, 1'b0);
        push(13'h108, 1'b0, 1'b1);
        push(13'h100, 1'b0, 1'b0);
        push(13'h104, 1'b0, 1'b0);
        push(13'h108, 1'b1, 1'b0);
    endtask

    task automatic start_cmd(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] g3,
                             input logic [ADDR_W-1:0] g2, input logic [CNT_W-1:0] l3,
                             input logic [CNT_W-1:0] l2, input logic [REP_W-1:0] r);
        @(posedge clk);
        #1;
        cmd_base_addr = base;
        cmd_gap       = '0;
        cmd_gap[3*ADDR_W +: ADDR_W] = g3;
        cmd_gap[2*ADDR_W +: ADDR_W] = g2;
        cmd_lenth     = '0;
        cmd_lenth[3*CNT_W +: CNT_W] = l3;
        cmd_lenth[2*CNT_W +: CNT_W] = l2;
        cmd_repeat_num = r;
        cmd_start      = 1'b1;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
    endtask

    // Counts negedges from the INIT cycle (index 0) until done is seen.
    task automatic wait_done(input logic chk_init, output int lat);
        lat = 0;
        @(negedge clk);
        if (chk_init) begin
            chk("init_mu_init", 32'(mu_init), 32'd1);
            chk("init_out_valid", 32'(out_valid), 32'd0);
            chk("init_busy", 32'(busy), 32'd1);
        end
        while (done !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done expected done within 400 cycles");
        end
    endtask

    task automatic finish_cmd(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_accepts(input int n);
        int target;
        int cyc;
        target = n_acc + n;
        cyc    = 0;
        while (n_acc < target && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (n_acc < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got %0d accepts expected %0d", n_acc, target);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
        chk({tag, "_mu_ctl"}, 32'({mu_init, mu_step, mu_record, mu_repeat}), 32'd0);
        chk({tag, "_mu_base"}, 32'(mu_base_addr), 32'd0);
        chk({tag, "_mu_cfg"}, 32'(|{mu_gap, mu_lenth}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst            = 1'b1;
        cmd_start      = 1'b0;
        cmd_abort      = 1'b0;
        cmd_base_addr  = '0;
        cmd_gap        = '0;
        cmd_lenth      = '0;
        cmd_repeat_num = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("rst");
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_rst");

        // T1: single-beat command
        push(13'h100, 1'b1, 1'b0);
        start_cmd(13'h100, '0, '0, '0, '0, '0);
        wait_done(1'b1, lat);
        chk("t1_done_lat", 32'(lat), 32'd2);
        finish_cmd("t1");

        // T2: loop3 sweep of 3 with one replay
        push_t2();
        start_cmd(13'h100, 13'h4, '0, 13'd2, '0, 8'd1);
        wait_done(1'b0, lat);
        chk("t2_done_lat", 32'(lat), 32'd7);
        finish_cmd("t2");

        // T3: add loop2 of 2 with gap 0x40
        push_t2();
        exp_q[5].last = 1'b0;
        push(13'h140, 1'b0, 1'b0);
        push(13'h144, 1'b0, 1'b0);
        push(13'h148, 1'b0, 1'b1);
        push(13'h140, 1'b0, 1'b0);
        push(13'h144, 1'b0, 1'b0);
        push(13'h148, 1'b1, 1'b0);
        start_cmd(13'h100, 13'h4, 13'h40, 13'd2, 13'd1, 8'd1);
        wait_done(1'b0, lat);
        chk("t3_done_lat", 32'(lat), 32'd13);
        finish_cmd("t3");

        // T4: T2 with a toggling consumer
        rdy_toggle = 1'b1;
        push_t2();
        start_cmd(13'h100, 13'h4, '0, 13'd2, '0, 8'd1);
        wait_done(1'b0, lat);
        rdy_toggle = 1'b0;
        finish_cmd("t4");

        // T5: abort after two accepts
        push(13'h100, 1'b0, 1'b0);
        push(13'h104, 1'b0, 1'b0);
        start_cmd(13'h100, 13'h4, '0, 13'd2, '0, 8'd1);
        wait_accepts(2);
        @(posedge clk);
        #1;
        cmd_abort = 1'b1;
        @(negedge clk);
        chk("t5_abort_valid", 32'(out_valid), 32'd0);
        chk("t5_abort_step", 32'({mu_step, mu_repeat}), 32'd0);
        @(posedge clk);
        #1;
        cmd_abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_done", 32'(done), 32'd0);
            chk("t5_busy", 32'(busy), 32'd0);
        end
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // Start together with abort in IDLE is dropped
        @(posedge clk);
        #1;
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        @(negedge clk);
        chk("t5_start_abort_idle", 32'(busy), 32'd0);

        // Replay from base; a start while busy must not disturb the command
        push_t2();
        start_cmd(13'h100, 13'h4, '0, 13'd2, '0, 8'd1);
        @(posedge clk);
        #1;
        cmd_start     = 1'b1;
        cmd_base_addr = 13'h500;
        @(posedge clk);
        #1;
        cmd_start     = 1'b0;
        cmd_base_addr = 13'h100;
        chk("t5_busy_start_ignored", 32'(mu_base_addr), 32'h100);
        wait_done(1'b0, lat);
        finish_cmd("t5");

        // T6: reset mid-run, then a fresh T2
        push_t2();
        start_cmd(13'h100, 13'h4, '0, 13'd2, '0, 8'd1);
        wait_accepts(2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle("t6_async_rst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("t6_post_rst");
        push_t2();
        start_cmd(13'h100, 13'h4, '0, 13'd2, '0, 8'd1);
        wait_done(1'b1, lat);
        chk("t6_done_lat", 32'(lat), 32'd7);
        finish_cmd("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
